muldiv_sign_seq: RTL and testbench

- Sign-handling sequencer for the iterative 64-bit multiply/divide unit.
- Time-multiplexes one shared external 64-bit two's-complement negator (combinational, dataout = -datain mod 2^64) across three jobs:
  - operand A absolute value
  - operand B absolute value
  - result sign fix-up (128-bit product, or quotient/remainder)
- Hands unsigned magnitudes to the unsigned core and returns the signed-corrected result through a valid/ready handshake.

---
 rtl/muldiv_sign_seq_if.sv | 44 ++++
 rtl/muldiv_sign_seq.sv | 154 +++++++++++++++
 tb/tb_muldiv_sign_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sign_seq_if.sv
// Bundle between the sign sequencer, its requester, the shared negator,
// the unsigned mul/div core and the result consumer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface muldiv_sign_seq_if #(
  parameter int XLEN = 64
);
  // request side
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            in_a_signed;
  logic            in_b_signed;
  logic            in_is_div;
  // shared negator
  logic [XLEN-1:0] comp_in;
  logic [XLEN-1:0] comp_out;
  // unsigned core
  logic            core_start;
  logic [XLEN-1:0] core_a;
  logic [XLEN-1:0] core_b;
  logic            core_done;
  logic [XLEN-1:0] core_hi;
  logic [XLEN-1:0] core_lo;
  // result side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_hi;
  logic [XLEN-1:0] out_lo;

  modport slave (
    input  in_valid, in_a, in_b, in_a_signed, in_b_signed, in_is_div,
    input  comp_out, core_done, core_hi, core_lo, out_ready,
    output in_ready, comp_in, core_start, core_a, core_b,
    output out_valid, out_hi, out_lo
  );

  modport master (
    output in_valid, in_a, in_b, in_a_signed, in_b_signed, in_is_div,
    output comp_out, core_done, core_hi, core_lo, out_ready,
    input  in_ready, comp_in, core_start, core_a, core_b,
    input  out_valid, out_hi, out_lo
  );
endinterface

// File: rtl/muldiv_sign_seq.sv
// Sign sequencer: strips operand signs through one shared negator, runs the unsigned core, re-applies result signs.
// Latency: operand negations + 1 (start) + core cycles + result negations + 1 cycle to present the result.
// Backpressure: one job in flight; in_ready stays low until the result is taken, DONE holds outputs while out_ready=0.
module muldiv_sign_seq #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_sign_seq_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_RUN, S_WAIT, S_NEG_LO, S_NEG_HI, S_DONE
  } state_t;

  state_t          r_state;
  logic            r_sa, r_sb, r_bz, r_div, r_lz;
  logic            r_neg_lo, r_neg_hi;
  logic [XLEN-1:0] r_core_a, r_core_b;
  logic [XLEN-1:0] r_out_hi, r_out_lo;
  logic [XLEN-1:0] r_comp_in;
  logic            r_in_ready, r_out_valid, r_core_start;

  logic w_accept, w_sa, w_sb, w_neg_lo, w_neg_hi;

  assign w_accept = io_bus.in_valid & r_in_ready;
  assign w_sa     = io_bus.in_a_signed & io_bus.in_a[XLEN-1];
  assign w_sb     = io_bus.in_b_signed & io_bus.in_b[XLEN-1];
  // Quotient is left alone on divide-by-zero; remainder follows the dividend.
  assign w_neg_lo = r_div ? ((r_sa ^ r_sb) & ~r_bz) : (r_sa ^ r_sb);
  assign w_neg_hi = r_div ? r_sa : (r_sa ^ r_sb);

  assign io_bus.in_ready   = r_in_ready;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.core_start = r_core_start;
  assign io_bus.core_a     = r_core_a;
  assign io_bus.core_b     = r_core_b;
  assign io_bus.out_hi     = r_out_hi;
  assign io_bus.out_lo     = r_out_lo;
  assign io_bus.comp_in    = r_comp_in;

  // Sequencer: comp_in is loaded on entry to each NEG_* state so the negator sees
  // the value to flip for exactly that cycle and sits at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sa         <= 1'b0;
      r_sb         <= 1'b0;
      r_bz         <= 1'b0;
      r_div        <= 1'b0;
      r_lz         <= 1'b0;
      r_neg_lo     <= 1'b0;
      r_neg_hi     <= 1'b0;
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_out_hi     <= '0;
      r_out_lo     <= '0;
      r_comp_in    <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_core_start <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_comp_in    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sa       <= w_sa;
            r_sb       <= w_sb;
            r_bz       <= (io_bus.in_b == '0);
            r_div      <= io_bus.in_is_div;
            r_core_a   <= io_bus.in_a;
            r_core_b   <= io_bus.in_b;
            r_in_ready <= 1'b0;
            if (w_sa) begin
              r_state   <= S_NEG_A;
              r_comp_in <= io_bus.in_a;
            end else if (w_sb) begin
              r_state   <= S_NEG_B;
              r_comp_in <= io_bus.in_b;
            end else begin
              r_state      <= S_RUN;
              r_core_start <= 1'b1;
            end
          end
        end
        S_NEG_A: begin
          r_core_a <= io_bus.comp_out;
          if (r_sb) begin
            r_state   <= S_NEG_B;
            r_comp_in <= r_core_b;
          end else begin
            r_state      <= S_RUN;
            r_core_start <= 1'b1;
          end
        end
        S_NEG_B: begin
          r_core_b     <= io_bus.comp_out;
          r_state      <= S_RUN;
          r_core_start <= 1'b1;
        end
        S_RUN: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (io_bus.core_done) begin
            r_out_hi <= io_bus.core_hi;
            r_out_lo <= io_bus.core_lo;
            r_lz     <= (io_bus.core_lo == '0);
            r_neg_lo <= w_neg_lo;
            r_neg_hi <= w_neg_hi;
            if (w_neg_lo) begin
              r_state   <= S_NEG_LO;
              r_comp_in <= io_bus.core_lo;
            end else if (w_neg_hi) begin
              r_state   <= S_NEG_HI;
              r_comp_in <= io_bus.core_hi;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_NEG_LO: begin
          r_out_lo <= io_bus.comp_out;
          if (r_neg_hi) begin
            r_state   <= S_NEG_HI;
            r_comp_in <= r_out_hi;
          end else begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_NEG_HI: begin
          // 128-bit negate: the low-half carry only reaches hi when lo was zero.
          r_out_hi    <= (r_div | r_lz) ? io_bus.comp_out : ~r_out_hi;
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (io_bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sign_seq.sv
// Bench for muldiv_sign_seq: acts as requester, shared negator, unsigned core
// and result consumer; checks directed vectors, random traffic and reset abort.
module tb_muldiv_sign_seq;

  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  muldiv_sign_seq_if #(.XLEN(64)) bus ();

  muldiv_sign_seq #(.XLEN(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  // external two's-complement negator
  assign bus.comp_out = -bus.comp_in;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    bit          as_;
    bit          bs_;
    bit          dv;
    int          lat;
    int          bp;
    logic [63:0] ehi;
    logic [63:0] elo;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned result straight from arithmetic rules.
  function automatic logic [127:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                             input bit as_, input bit bs_, input bit dv);
    logic [127:0] ea, eb;
    longint       sa, sb;
    logic [63:0]  q, r;
    if (!dv) begin
      ea = as_ ? {{64{a[63]}}, a} : {64'd0, a};
      eb = bs_ ? {{64{b[63]}}, b} : {64'd0, b};
      return ea * eb;
    end
    if (b == 64'd0) begin
      q = ONES;
      r = a;
    end else if (as_ && a == MIN && b == ONES) begin
      q = MIN;
      r = 64'd0;
    end else if (as_) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = ONES;
      3: v = MIN;
      4: v = 64'h7FFF_FFFF_FFFF_FFFF;
      5: v = 64'($urandom_range(0, 1000));
      6: v = -64'($urandom_range(1, 1000));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " in_ready"},   64'(bus.in_ready),   64'd1);
    check({tag, " out_valid"},  64'(bus.out_valid),  64'd0);
    check({tag, " core_start"}, 64'(bus.core_start), 64'd0);
    check({tag, " core_a"},     bus.core_a,          64'd0);
    check({tag, " core_b"},     bus.core_b,          64'd0);
    check({tag, " out_hi"},     bus.out_hi,          64'd0);
    check({tag, " out_lo"},     bus.out_lo,          64'd0);
    check({tag, " comp_in"},    bus.comp_in,         64'd0);
  endtask

  task automatic run_txn(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input bit as_, input bit bs_, input bit dv,
                         input int lat, input int bp,
                         input logic [63:0] ehi, input logic [63:0] elo);
    bit          sa, sb, nlo, nhi, pend, ready_ok, stable_ok;
    logic [63:0] exp_ca, exp_cb, got_ca, got_cb, rhi, rlo;
    int          cyc, starts, cd, exp_lat;
    sa      = as_ & a[63];
    sb      = bs_ & b[63];
    exp_ca  = sa ? -a : a;
    exp_cb  = sb ? -b : b;
    nlo     = dv ? ((sa ^ sb) && (b != 64'd0)) : (sa ^ sb);
    nhi     = dv ? sa : (sa ^ sb);
    exp_lat = int'(sa) + int'(sb) + 1 + (lat + 1) + int'(nlo) + int'(nhi);

    bus.in_a        = a;
    bus.in_b        = b;
    bus.in_a_signed = as_;
    bus.in_b_signed = bs_;
    bus.in_is_div   = dv;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;

    cyc = 0; starts = 0; cd = 0; pend = 1'b0; ready_ok = 1'b1;
    got_ca = '0; got_cb = '0; rhi = '0; rlo = '0;
    while (!bus.out_valid && cyc < 200) begin
      bus.core_done = 1'b0;
      if (pend) begin
        if (cd == 0) begin
          bus.core_done = 1'b1;
          bus.core_hi   = rhi;
          bus.core_lo   = rlo;
          pend          = 1'b0;
        end else begin
          cd--;
        end
      end
      if (bus.core_start) begin
        starts++;
        got_ca = bus.core_a;
        got_cb = bus.core_b;
        if (!dv) begin
          {rhi, rlo} = {64'd0, got_ca} * {64'd0, got_cb};
        end else if (got_cb == 64'd0) begin
          rlo = ONES;
          rhi = got_ca;
        end else begin
          rlo = got_ca / got_cb;
          rhi = got_ca % got_cb;
        end
        pend = 1'b1;
        cd   = lat;
      end
      if (bus.in_ready) ready_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.core_done = 1'b0;

    check({tag, " finished"},   64'(bus.out_valid), 64'd1);
    check({tag, " core_a"},     got_ca,             exp_ca);
    check({tag, " core_b"},     got_cb,             exp_cb);
    check({tag, " starts"},     64'(starts),        64'd1);
    check({tag, " latency"},    64'(cyc),           64'(exp_lat));
    check({tag, " busy_ready"}, 64'(ready_ok),      64'd1);
    check({tag, " out_hi"},     bus.out_hi,         ehi);
    check({tag, " out_lo"},     bus.out_lo,         elo);

    stable_ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.in_ready || bus.out_hi !== ehi || bus.out_lo !== elo)
        stable_ok = 1'b0;
    end
    if (bp > 0) check({tag, " held"}, 64'(stable_ok), 64'd1);

    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, " post_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " post_ready"}, 64'(bus.in_ready),  64'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0] r;
    logic [63:0]  a, b;
    bit           as_, bs_, dv;
    bit           seen, quiet;

    tbl[0]  = '{64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 1, 0, 64'd0, 64'd15};
    tbl[1]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b1, 1'b0, 2, 1, ONES, 64'hFFFF_FFFF_FFFF_FFF1};
    tbl[2]  = '{ONES, MIN, 1'b1, 1'b0, 1'b0, 0, 0, ONES, MIN};
    tbl[3]  = '{64'hFFFF_FFFF_FFFF_FFFE, MIN, 1'b1, 1'b0, 1'b0, 3, 0, ONES, 64'd0};
    tbl[4]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b1, 1, 0, ONES, 64'hFFFF_FFFF_FFFF_FFFD};
    tbl[5]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b1, 1'b1, 1'b1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, ONES};
    tbl[6]  = '{MIN, ONES, 1'b1, 1'b1, 1'b1, 2, 5, 64'd0, MIN};
    tbl[7]  = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b1, 1, 0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD};
    tbl[8]  = '{64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 0, 2, 64'd2, 64'd14};
    tbl[9]  = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b1, 1'b0, 1, 0, 64'd0, 64'd24};
    tbl[10] = '{ONES, ONES, 1'b0, 1'b0, 1'b0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_a        = '0;
    bus.in_b        = '0;
    bus.in_a_signed = 1'b0;
    bus.in_b_signed = 1'b0;
    bus.in_is_div   = 1'b0;
    bus.core_done   = 1'b0;
    bus.core_hi     = '0;
    bus.core_lo     = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].as_, tbl[i].bs_, tbl[i].dv,
              tbl[i].lat, tbl[i].bp, tbl[i].ehi, tbl[i].elo);

    for (int i = 0; i < 60; i++) begin
      a   = rnd_op();
      b   = rnd_op();
      dv  = 1'($urandom_range(0, 1));
      as_ = 1'($urandom_range(0, 1));
      bs_ = dv ? as_ : 1'($urandom_range(0, 1));
      r   = ref_model(a, b, as_, bs_, dv);
      run_txn($sformatf("rnd%0d", i), a, b, as_, bs_, dv,
              $urandom_range(0, 3), $urandom_range(0, 2), r[127:64], r[63:0]);
    end

    // Abort while the core is busy: the late core_done must be ignored.
    bus.in_a        = 64'hFFFF_FFFF_FFFF_FFF9;
    bus.in_b        = 64'hFFFF_FFFF_FFFF_FFFD;
    bus.in_a_signed = 1'b1;
    bus.in_b_signed = 1'b1;
    bus.in_is_div   = 1'b1;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.core_start) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("abort start_seen", 64'(seen), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_idle("abort in_reset");
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.core_hi   = 64'd1;
    bus.core_lo   = 64'd2;
    bus.core_done = 1'b1;
    @(posedge clk); #1;
    bus.core_done = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid || !bus.in_ready) quiet = 1'b0;
      @(posedge clk); #1;
    end
    check("abort quiet", 64'(quiet), 64'd1);
    check_idle("abort after");

    run_txn("recover", tbl[1].a, tbl[1].b, tbl[1].as_, tbl[1].bs_, tbl[1].dv,
            tbl[1].lat, tbl[1].bp, tbl[1].ehi, tbl[1].elo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
